// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V main control FSM (FETCH/DECODE/EXECUTE/MEM/WB/HALT)
// Inputs : clk, rst, instr_valid_i, opcode_i, funct7_i, mem_ready_i, muldiv_done_i
// Outputs: instr_req_o, ir_write_o, datapath controls (reg_write_o .. auipc_o, alu_op_o, word_o),
//          muldiv_start_o, pc_write_o, halt_o, state_o, retired_o
module multicycle_control #(
    parameter int XLEN            = 64,
    parameter int M_EXT           = 1,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    input  logic [6:0]       opcode_i,
    input  logic [6:0]       funct7_i,
    input  logic             mem_ready_i,
    input  logic             muldiv_done_i,
    output logic             instr_req_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             branch_o,
    output logic             jump_o,
    output logic             jump_reg_o,
    output logic             lui_o,
    output logic             auipc_o,
    output logic [1:0]       alu_op_o,
    output logic             word_o,
    output logic             muldiv_start_o,
    output logic             pc_write_o,
    output logic             halt_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7;
    typedef struct packed {
        logic       rw, src, mr, mw, br, j, jr, lui, aui;
        logic [1:0] op;
        logic       wd, md;
    } ctrl_t;
    logic [2:0]       state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [6:0]       op_q, f7_q;
    logic             started_q, sys, illegal, md_enc, in_ex, ex_done;
    logic [CNT_W-1:0] retired_q;
    // The instruction is captured with IRWrite so that DECODE-state outputs
    // depend only on registered state, never combinationally on opcode_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            op_q      <= '0;
            f7_q      <= '0;
            started_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            if (ir_write_o) begin
                op_q <= opcode_i;
                f7_q <= funct7_i;
            end
            if (state_q == S_DECODE) ctrl_q <= ctrl_d;
            started_q <= in_ex && state_d == S_EXEC;
            retired_q <= retired_q + CNT_W'(pc_write_o);
        end
    end
    always_comb begin
        ctrl_d  = '0;
        sys     = 1'b0;
        illegal = 1'b0;
        md_enc  = f7_q == 7'b0000001;
        case (op_q)
            7'b0110011: begin ctrl_d.op = 2'b10; ctrl_d.rw = 1'b1; ctrl_d.md = md_enc;
                              illegal = md_enc && M_EXT == 0; end
            7'b0010011: begin ctrl_d.op = 2'b11; ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; end
            7'b0000011: begin ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; ctrl_d.mr = 1'b1; end
            7'b0100011: begin ctrl_d.src = 1'b1; ctrl_d.mw = 1'b1; end
            7'b1100011: begin ctrl_d.op = 2'b01; ctrl_d.br = 1'b1; end
            7'b1101111: begin ctrl_d.rw = 1'b1; ctrl_d.j = 1'b1; end
            7'b1100111: begin ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; ctrl_d.jr = 1'b1; end
            7'b0110111: begin ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; ctrl_d.lui = 1'b1; end
            7'b0010111: begin ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; ctrl_d.aui = 1'b1; end
            7'b0011011: begin ctrl_d.op = 2'b11; ctrl_d.src = 1'b1; ctrl_d.rw = 1'b1; ctrl_d.wd = 1'b1;
                              illegal = XLEN != 64; end
            7'b0111011: begin ctrl_d.op = 2'b10; ctrl_d.rw = 1'b1; ctrl_d.wd = 1'b1; ctrl_d.md = md_enc;
                              illegal = XLEN != 64 || (md_enc && M_EXT == 0); end
            7'b1110011: sys = 1'b1;
            default:    illegal = 1'b1;
        endcase
        // Illegal instructions retire as NOPs, so their control vector is all zero.
        if (illegal) ctrl_d = '0;
        in_ex   = state_q == S_EXEC;
        ex_done = !ctrl_q.md || muldiv_done_i;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = instr_valid_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (sys || (illegal && HALT_ON_ILLEGAL != 0)) ? S_HALT :
                                illegal ? S_FETCH : S_EXEC;
            S_EXEC:   if (ex_done) state_d = ctrl_q.br ? S_FETCH : (ctrl_q.mr || ctrl_q.mw) ? S_MEM : S_WB;
            S_MEM:    if (mem_ready_i) state_d = ctrl_q.mw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end
    always_comb begin
        instr_req_o    = state_q == S_FETCH;
        ir_write_o     = state_q == S_FETCH && instr_valid_i;
        reg_write_o    = state_q == S_WB && ctrl_q.rw;
        mem_read_o     = state_q == S_MEM && ctrl_q.mr;
        mem_write_o    = state_q == S_MEM && ctrl_q.mw;
        alu_src_o      = in_ex && ctrl_q.src;
        branch_o       = in_ex && ctrl_q.br;
        jump_o         = in_ex && ctrl_q.j;
        jump_reg_o     = in_ex && ctrl_q.jr;
        lui_o          = in_ex && ctrl_q.lui;
        auipc_o        = in_ex && ctrl_q.aui;
        word_o         = in_ex && ctrl_q.wd;
        alu_op_o       = in_ex ? ctrl_q.op : 2'b00;
        // started_q marks every EXECUTE cycle after the first, so the start is a single pulse.
        muldiv_start_o = in_ex && ctrl_q.md && !started_q;
        pc_write_o     = (state_q == S_DECODE && illegal && HALT_ON_ILLEGAL == 0) ||
                         (in_ex && ex_done && ctrl_q.br) ||
                         (state_q == S_MEM && mem_ready_i && ctrl_q.mw) ||
                         state_q == S_WB;
        halt_o         = state_q == S_HALT;
        state_o        = state_q;
        retired_o      = retired_q;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control across three parameter sets
module tb_multicycle_control;
    logic       clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0, muldiv_done = 1'b0;
    logic [6:0] opcode = '0, funct7 = '0, cur_op = '0, cur_f7 = '0;
    logic [2:0][19:0] obs;
    logic [2:0][31:0] ret;
    int ncmp = 0, nfail = 0;
    always #5 clk = ~clk;
    // Instance 0: defaults. Instance 1: XLEN=32, M_EXT=0, CNT_W=4. Instance 2: HALT_ON_ILLEGAL=0.
    for (genvar k = 0; k < 3; k++) begin : g
        localparam int CW = (k == 1) ? 4 : 32;
        logic irq, irw, rw, src, mr, mw, br, j, jr, lui, aui, wd, mds, pcw, hlt;
        logic [1:0]    op;
        logic [2:0]    st;
        logic [CW-1:0] r;
        multicycle_control #(
            .XLEN(k == 1 ? 32 : 64), .M_EXT(k == 1 ? 0 : 1),
            .HALT_ON_ILLEGAL(k == 2 ? 0 : 1), .CNT_W(CW)
        ) u (
            .clk(clk), .rst(rst), .instr_valid_i(instr_valid), .opcode_i(opcode), .funct7_i(funct7),
            .mem_ready_i(mem_ready), .muldiv_done_i(muldiv_done), .instr_req_o(irq), .ir_write_o(irw),
            .reg_write_o(rw), .alu_src_o(src), .mem_read_o(mr), .mem_write_o(mw), .branch_o(br),
            .jump_o(j), .jump_reg_o(jr), .lui_o(lui), .auipc_o(aui), .alu_op_o(op), .word_o(wd),
            .muldiv_start_o(mds), .pc_write_o(pcw), .halt_o(hlt), .state_o(st), .retired_o(r)
        );
        assign obs[k] = {st, irq, irw, rw, src, mr, mw, br, j, jr, lui, aui, op, wd, mds, pcw, hlt};
        assign ret[k] = 32'(r);
    end
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd7;
    localparam logic [16:0] IRQ = 17'h10000, IRW = 17'h08000, RW = 17'h04000, SRC = 17'h02000,
                            MR = 17'h01000, MW = 17'h00800, BR = 17'h00400, J = 17'h00200,
                            JR = 17'h00100, LUI = 17'h00080, AUI = 17'h00040, OPS = 17'h00010,
                            OPR = 17'h00020, OPI = 17'h00030, WD = 17'h00008, MDS = 17'h00004,
                            PCW = 17'h00002, HLT = 17'h00001, NONE = 17'h00000;
    typedef struct {
        logic [6:0]  op, f7;
        logic        v, mr, md;
        logic [19:0] e;
    } stim_t;
    stim_t sq[$];
    logic [19:0] e;

    task automatic push(input logic v, input logic mr, input logic md, input logic [2:0] st,
                        input logic [16:0] s);
        sq.push_back('{cur_op, cur_f7, v, mr, md, {st, s}});
    endtask

    task automatic apply(output logic [19:0] exp_v);
        stim_t s;
        s = sq.pop_front();
        @(negedge clk);
        opcode = s.op; funct7 = s.f7;
        instr_valid = s.v; mem_ready = s.mr; muldiv_done = s.md;
        #1;
        exp_v = s.e;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; muldiv_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== {F, IRQ}) begin nfail++; $display("FAIL reset_out[%0d]: got %h want %h", k, obs[k], {F, IRQ}); end
            ncmp++;
            if (ret[k] !== 32'd0) begin nfail++; $display("FAIL reset_ret[%0d]: got %0d want 0", k, ret[k]); end
        end
    endtask

    task automatic test_add;
        do_reset();
        cur_op = 7'b0110011; cur_f7 = 7'b0000000;
        push(1, 1, 1, F, IRQ | IRW); push(1, 1, 1, D, NONE); push(1, 1, 1, E, OPR);
        push(1, 1, 1, W, RW | PCW);  push(0, 0, 0, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL add: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd1) begin nfail++; $display("FAIL add_ret: got %0d want 1", ret[0]); end
    endtask

    task automatic test_load;
        do_reset();
        cur_op = 7'b0000011; cur_f7 = 7'b0000000;
        push(1, 1, 1, F, IRQ | IRW); push(0, 1, 1, D, NONE); push(0, 1, 1, E, SRC);
        for (int i = 0; i < 3; i++) push(0, 0, 0, M, MR);
        push(0, 1, 0, M, MR); push(0, 0, 0, W, RW | PCW); push(0, 0, 0, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL load: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd1) begin nfail++; $display("FAIL load_ret: got %0d want 1", ret[0]); end
    endtask

    task automatic test_muldiv;
        do_reset();
        cur_op = 7'b0110011; cur_f7 = 7'b0000001;
        push(1, 0, 1, F, IRQ | IRW); push(0, 0, 1, D, NONE); push(0, 0, 0, E, OPR | MDS);
        for (int i = 0; i < 4; i++) push(0, 0, 0, E, OPR);
        push(0, 0, 1, E, OPR); push(0, 0, 0, W, RW | PCW); push(0, 0, 0, F, IRQ);
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(0, 0, 1, E, OPR | MDS);
        push(0, 0, 0, W, RW | PCW);  push(0, 0, 0, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL muldiv: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd2) begin nfail++; $display("FAIL muldiv_ret: got %0d want 2", ret[0]); end
        do_reset();
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(1, 1, 1, H, HLT); push(1, 1, 1, H, HLT);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[1] !== e) begin nfail++; $display("FAIL muldiv_noext: got %h want %h", obs[1], e); end
        end
        ncmp++;
        if (ret[1] !== 32'd0) begin nfail++; $display("FAIL muldiv_noext_ret: got %0d want 0", ret[1]); end
    endtask

    task automatic test_word;
        do_reset();
        cur_op = 7'b0011011; cur_f7 = 7'b0000000;
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(0, 0, 0, E, OPI | SRC | WD);
        push(0, 0, 0, W, RW | PCW);  push(0, 0, 0, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL addiw64: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd1) begin nfail++; $display("FAIL addiw64_ret: got %0d want 1", ret[0]); end
        do_reset();
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(1, 1, 1, H, HLT); push(1, 1, 1, H, HLT);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[1] !== e) begin nfail++; $display("FAIL addiw32: got %h want %h", obs[1], e); end
        end
        ncmp++;
        if (ret[1] !== 32'd0) begin nfail++; $display("FAIL addiw32_ret: got %0d want 0", ret[1]); end
    endtask

    task automatic test_illegal_nop;
        do_reset();
        cur_op = 7'b1111111; cur_f7 = 7'b0000000;
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, PCW); push(0, 1, 1, F, IRQ); push(0, 1, 1, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[2] !== e) begin nfail++; $display("FAIL illegal_nop: got %h want %h", obs[2], e); end
        end
        ncmp++;
        if (ret[2] !== 32'd1) begin nfail++; $display("FAIL illegal_nop_ret: got %0d want 1", ret[2]); end
    endtask

    task automatic test_system_halt;
        do_reset();
        cur_op = 7'b0110111; cur_f7 = 7'b0000000;
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(0, 0, 0, E, SRC | LUI);
        push(1, 0, 0, W, RW | PCW);
        cur_op = 7'b0010111;
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE); push(0, 0, 0, E, SRC | AUI);
        push(0, 0, 0, W, RW | PCW);
        cur_op = 7'b1110011;
        push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE);
        for (int i = 0; i < 4; i++) push(1, 1, 1, H, HLT);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL system: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd2) begin nfail++; $display("FAIL system_ret: got %0d want 2", ret[0]); end
        do_reset();
        #1;
        ncmp++;
        if (obs[0] !== {F, IRQ}) begin nfail++; $display("FAIL halt_rst: got %h want %h", obs[0], {F, IRQ}); end
        ncmp++;
        if (ret[0] !== 32'd0) begin nfail++; $display("FAIL halt_rst_ret: got %0d want 0", ret[0]); end
    endtask

    task automatic test_wrap;
        do_reset();
        cur_op = 7'b1100011; cur_f7 = 7'b0000000;
        for (int n = 1; n <= 16; n++) begin
            push(1, 0, 0, F, IRQ | IRW); push(1, 0, 0, D, NONE); push(1, 0, 0, E, OPS | BR | PCW);
            push(0, 0, 0, F, IRQ);
            while (sq.size() > 0) begin
                apply(e); ncmp++;
                if (obs[1] !== e) begin nfail++; $display("FAIL branch%0d: got %h want %h", n, obs[1], e); end
            end
            if (n == 15 || n == 16) begin
                ncmp++;
                if (ret[1] !== 32'(n % 16)) begin nfail++; $display("FAIL wrap%0d: got %0d want %0d", n, ret[1], n % 16); end
            end
        end
    endtask

    task automatic test_store_reset;
        do_reset();
        cur_op = 7'b0100011; cur_f7 = 7'b0000000;
        push(1, 0, 0, F, IRQ | IRW); push(0, 1, 0, D, NONE); push(0, 1, 0, E, SRC);
        push(0, 1, 0, M, MW | PCW);  push(1, 0, 0, F, IRQ | IRW); push(0, 0, 0, D, NONE);
        push(0, 0, 0, E, SRC);       push(0, 0, 0, M, MW); push(0, 0, 0, M, MW);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL store: got %h want %h", obs[0], e); end
        end
        ncmp++;
        if (ret[0] !== 32'd1) begin nfail++; $display("FAIL store_ret: got %0d want 1", ret[0]); end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        ncmp++;
        if (obs[0] !== {F, IRQ}) begin nfail++; $display("FAIL mem_rst: got %h want %h", obs[0], {F, IRQ}); end
        ncmp++;
        if (ret[0] !== 32'd0) begin nfail++; $display("FAIL mem_rst_ret: got %0d want 0", ret[0]); end
        push(0, 1, 0, F, IRQ); push(0, 1, 0, F, IRQ);
        while (sq.size() > 0) begin
            apply(e); ncmp++;
            if (obs[0] !== e) begin nfail++; $display("FAIL post_rst: got %h want %h", obs[0], e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_muldiv();
        test_word();
        test_illegal_nop();
        test_system_halt();
        test_wrap();
        test_store_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
